// File: rtl/time_display_scan_pkg.sv
// ---------------------------------------------------------------------------
// time_display_scan_pkg
// Shared constants for the multiplexed six-digit time display:
//   - SEG_* glyphs, active-high, bit0 = segment a ... bit6 = segment g
//   - display geometry (digit count, decimal-point mask, all-off pin levels)
//   - helper that selects one BCD nibble out of the packed {h,m,s} word
// ---------------------------------------------------------------------------
package time_display_scan_pkg;

  localparam int NUM_DIGITS = 6;

  // Digits 2 and 4 carry the point, giving hh.mm.ss.
  localparam logic [5:0] DP_MASK = 6'b010100;

  localparam logic [6:0] SEG_0    = 7'b0111111;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_3    = 7'b1001111;
  localparam logic [6:0] SEG_4    = 7'b1100110;
  localparam logic [6:0] SEG_5    = 7'b1101101;
  localparam logic [6:0] SEG_6    = 7'b1111101;
  localparam logic [6:0] SEG_7    = 7'b0000111;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1101111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;

  // Pin levels with everything dark (all signals active-low).
  localparam logic [5:0] AN_OFF_N  = 6'h3F;
  localparam logic [6:0] SEG_OFF_N = 7'h7F;

  typedef logic [2:0] digit_idx_t;

  localparam digit_idx_t LAST_DIGIT = 3'(NUM_DIGITS - 1);

  // Digit 0 is the seconds ones nibble, digit 5 the hours tens nibble.
  function automatic logic [3:0] digit_nibble(input logic [23:0] hms,
                                              input digit_idx_t  d);
    logic [3:0] nib;
    case (d)
      3'd0:    nib = hms[3:0];
      3'd1:    nib = hms[7:4];
      3'd2:    nib = hms[11:8];
      3'd3:    nib = hms[15:12];
      3'd4:    nib = hms[19:16];
      3'd5:    nib = hms[23:20];
      default: nib = 4'd0;
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/time_display_scan_seg7.sv
// ---------------------------------------------------------------------------
// bcd_to_seg7
// Combinational BCD nibble to active-low 7-segment pattern.
//   nibble  in  4  BCD digit; values above 9 render as a dash
//   seg_n   out 7  active-low segments, bit0 = a ... bit6 = g
// ---------------------------------------------------------------------------
module bcd_to_seg7
  import time_display_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  // Glyph lookup; the table is active-high so invert for the pins.
  always_comb begin
    seg_n = ~SEG_DASH;
    case (nibble)
      4'd0:    seg_n = ~SEG_0;
      4'd1:    seg_n = ~SEG_1;
      4'd2:    seg_n = ~SEG_2;
      4'd3:    seg_n = ~SEG_3;
      4'd4:    seg_n = ~SEG_4;
      4'd5:    seg_n = ~SEG_5;
      4'd6:    seg_n = ~SEG_6;
      4'd7:    seg_n = ~SEG_7;
      4'd8:    seg_n = ~SEG_8;
      4'd9:    seg_n = ~SEG_9;
      default: seg_n = ~SEG_DASH;
    endcase
  end

endmodule

// File: rtl/time_display_scan.sv
// ---------------------------------------------------------------------------
// time_display_scan
// Time-multiplexes six packed-BCD time digits onto one shared 7-segment bus.
// The time is captured once per frame into shadow registers so a frame never
// mixes old and new values. Each digit slot starts with a short all-off
// window to suppress ghosting on the shared segment lines.
//   clk         in   1  clock
//   resetn      in   1  asynchronous active-low reset
//   h, m, s     in   8  hours / minutes / seconds, packed BCD
//   an_n        out  6  digit enables, active-low (bit0 = s ones, bit5 = h tens)
//   seg_n       out  7  segments, active-low (bit0 = a ... bit6 = g)
//   dp_n        out  1  decimal point, active-low
//   frame_tick  out  1  one-cycle pulse after the shadow registers reload
// ---------------------------------------------------------------------------
module time_display_scan
  import time_display_scan_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] h,
  input  logic [7:0] m,
  input  logic [7:0] s,
  output logic [5:0] an_n,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic       frame_tick
);

  localparam int P_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [P_W-1:0] P_MAX     = P_W'(SCAN_DIV - 1);
  localparam logic [P_W-1:0] BLANK_VAL = P_W'(BLANK_CYC);

  logic [P_W-1:0] p_r;
  digit_idx_t     d_r;
  logic [23:0]    shadow_r;

  logic           slot_end_s;
  logic           frame_end_s;
  logic           blank_s;
  logic [3:0]     nibble_s;
  logic [6:0]     seg_dec_s;
  logic [5:0]     an_next_s;
  logic [6:0]     seg_next_s;
  logic           dp_next_s;

  assign slot_end_s  = (p_r == P_MAX);
  assign frame_end_s = slot_end_s && (d_r == LAST_DIGIT);
  assign blank_s     = (p_r < BLANK_VAL);
  assign nibble_s    = digit_nibble(shadow_r, d_r);

  bcd_to_seg7 u_dec (
    .nibble (nibble_s),
    .seg_n  (seg_dec_s)
  );

  // Prescaler and digit index: the index advances on each prescaler wrap.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      p_r <= '0;
      d_r <= 3'd0;
    end else if (slot_end_s) begin
      p_r <= '0;
      d_r <= (d_r == LAST_DIGIT) ? 3'd0 : d_r + 3'd1;
    end else begin
      p_r <= p_r + P_W'(1);
    end
  end

  // Shadow capture on the last cycle of the frame; the new value is on
  // display from the first slot of the next frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shadow_r <= 24'd0;
    end else if (frame_end_s) begin
      shadow_r <= {h, m, s};
    end else begin
      shadow_r <= shadow_r;
    end
  end

  // Next pin levels from the current slot position.
  always_comb begin
    an_next_s  = AN_OFF_N;
    seg_next_s = SEG_OFF_N;
    dp_next_s  = 1'b1;
    if (blank_s) begin
      an_next_s  = AN_OFF_N;
      seg_next_s = SEG_OFF_N;
      dp_next_s  = 1'b1;
    end else begin
      an_next_s  = ~(6'b000001 << d_r);
      seg_next_s = seg_dec_s;
      dp_next_s  = ~DP_MASK[d_r];
    end
  end

  // Output registers: pins lag the slot position by one cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      an_n       <= AN_OFF_N;
      seg_n      <= SEG_OFF_N;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      an_n       <= an_next_s;
      seg_n      <= seg_next_s;
      dp_n       <= dp_next_s;
      frame_tick <= frame_end_s;
    end
  end

endmodule

// File: tb/tb_time_display_scan.sv
// ---------------------------------------------------------------------------
// tb_time_display_scan
// Scoreboard bench: a reference model derived from a free-running cycle count
// pushes the expected pin state for every clock edge; a monitor pops and
// compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_time_display_scan;

  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;
  localparam int FRAME     = SCAN_DIV * 6;

  logic       clk;
  logic       resetn;
  logic [7:0] h, m, s;
  logic [5:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n;
  logic       frame_tick;

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       tick;
  } exp_t;

  exp_t        q[$];
  int          checks;
  int          errors;
  int          n;          // cycles since reset release (model time)
  logic [23:0] shown;      // time value the model says is on display
  int          mon_cyc;
  int          last_tick;

  time_display_scan #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .h          (h),
    .m          (m),
    .s          (s),
    .an_n       (an_n),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Active-high glyph built from its lit segment letters.
  function automatic logic [6:0] glyph(input logic [3:0] v);
    string      lit;
    logic [6:0] bits;
    case (v)
      4'd0:    lit = "abcdef";
      4'd1:    lit = "bc";
      4'd2:    lit = "abdeg";
      4'd3:    lit = "abcdg";
      4'd4:    lit = "bcfg";
      4'd5:    lit = "acdfg";
      4'd6:    lit = "acdefg";
      4'd7:    lit = "abc";
      4'd8:    lit = "abcdefg";
      4'd9:    lit = "abcdfg";
      default: lit = "g";
    endcase
    bits = 7'd0;
    for (int i = 0; i < lit.len(); i++) bits[int'(lit[i]) - 97] = 1'b1;
    return bits;
  endfunction

  // Pin state implied by a position in the scan and the displayed time.
  function automatic exp_t expect_at(input int cyc, input logic [23:0] t,
                                     input logic tk);
    exp_t e;
    int   pos, dig;
    logic [23:0] sh;
    pos = cyc % SCAN_DIV;
    dig = (cyc / SCAN_DIV) % 6;
    e.tick = tk;
    if (pos < BLANK_CYC) begin
      e.an = 6'h3F; e.seg = 7'h7F; e.dp = 1'b1;
    end else begin
      e.an = 6'h3F;
      e.an[dig] = 1'b0;
      sh = t >> (4 * dig);
      e.seg = ~glyph(sh[3:0]);
      e.dp = !(dig == 2 || dig == 4);
    end
    return e;
  endfunction

  // Reference model: one expected entry per rising edge.
  initial begin
    exp_t e;
    n = 0;
    shown = 24'd0;
    forever begin
      @(posedge clk);
      if (!resetn) begin
        n = 0;
        shown = 24'd0;
        e.an = 6'h3F; e.seg = 7'h7F; e.dp = 1'b1; e.tick = 1'b0;
        q.push_back(e);
      end else begin
        e = expect_at(n, shown, (n % FRAME) == FRAME - 1);
        q.push_back(e);
        if ((n % FRAME) == FRAME - 1) shown = {h, m, s};
        n = n + 1;
      end
    end
  end

  // Monitor: compare pins against the scoreboard away from the rising edge.
  initial begin
    exp_t e;
    int   lows;
    mon_cyc = 0;
    last_tick = -1;
    forever begin
      @(negedge clk);
      mon_cyc = mon_cyc + 1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks = checks + 1;
        if (an_n !== e.an || seg_n !== e.seg || dp_n !== e.dp ||
            frame_tick !== e.tick) begin
          errors = errors + 1;
          $display("FAIL scan t=%0t got an_n=%b seg_n=%b dp_n=%b tick=%b want an_n=%b seg_n=%b dp_n=%b tick=%b",
                   $time, an_n, seg_n, dp_n, frame_tick, e.an, e.seg, e.dp, e.tick);
        end
        lows = 0;
        for (int i = 0; i < 6; i++) if (an_n[i] === 1'b0) lows = lows + 1;
        checks = checks + 1;
        if (lows > 1) begin
          errors = errors + 1;
          $display("FAIL one_digit t=%0t got %0d digits lit, want at most 1", $time, lows);
        end
      end
      if (!resetn) begin
        last_tick = -1;
      end else if (frame_tick === 1'b1) begin
        if (last_tick >= 0) begin
          checks = checks + 1;
          if (mon_cyc - last_tick != FRAME) begin
            errors = errors + 1;
            $display("FAIL tick_period got %0d cycles, want %0d", mon_cyc - last_tick, FRAME);
          end
        end
        last_tick = mon_cyc;
      end
    end
  end

  // Wait (on falling edges) until the model reaches a given scan position.
  task automatic wait_pos(input int target, input string tag);
    int k;
    k = 0;
    while (n != target && k < 4 * FRAME) begin
      @(negedge clk);
      k = k + 1;
    end
    if (n != target) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s timeout got n=%0d want n=%0d", tag, n, target);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // Stimulus.
  initial begin
    int k;
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    h = 8'h12; m = 8'h34; s = 8'h56;

    // Reset held for 5 cycles.
    repeat (5) @(negedge clk);
    #1 resetn = 1'b1;

    // Second frame, digit3 slot: seconds tick over mid-frame.
    wait_pos(FRAME + 3 * SCAN_DIV + 4, "s_change");
    s = 8'h57;
    wait_pos(3 * FRAME + 5, "dash");
    s = 8'h3A;
    wait_pos(5 * FRAME, "random");

    // Random input changes at random moments, full byte range.
    repeat (8 * FRAME) begin
      @(negedge clk);
      if ($urandom_range(15) == 0) begin
        case ($urandom_range(2))
          0:       h = 8'($urandom);
          1:       m = 8'($urandom);
          default: s = 8'($urandom);
        endcase
      end
    end

    // Reset pulse in the digit3 slot; pins must drop without a clock edge.
    h = 8'h23; m = 8'h59; s = 8'h48;
    k = 0;
    while (!(((n % FRAME) / SCAN_DIV) == 3 && (n % SCAN_DIV) == 4) && k < 2 * FRAME) begin
      @(negedge clk);
      k = k + 1;
    end
    #1 resetn = 1'b0;
    #1;
    checks = checks + 1;
    if (an_n !== 6'h3F || seg_n !== 7'h7F || dp_n !== 1'b1 || frame_tick !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL async_off got an_n=%b seg_n=%b dp_n=%b tick=%b want 111111 1111111 1 0",
               an_n, seg_n, dp_n, frame_tick);
    end
    repeat (2) @(negedge clk);
    #1 resetn = 1'b1;
    repeat (2 * FRAME + 4) @(negedge clk);

    k = 0;
    while (q.size() > 0 && k < 10) begin
      @(negedge clk);
      k = k + 1;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
